// File: rtl/core_run_ctrl.sv
// Debug run/halt sequencer: turns halt/resume/ebreak/step events into pipeline run/halt qualifiers.
// Moore outputs registered one cycle after the event; dpc_capture is combinational in the halt cycle.
module core_run_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 16,
  parameter bit          RESET_HALT    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       haltreq,
  input  logic       resumereq,
  input  logic       step,
  input  logic       ebreak_dbg,
  input  logic       instr_retired,
  input  logic       bus_busy,
  output logic       core_running,
  output logic       core_halted,
  output logic       dbg_ret,
  output logic       halted,
  output logic       resume_ack,
  output logic       dpc_capture,
  output logic [2:0] dcsr_cause,
  output logic       drain_timeout
);

  localparam logic [7:0] CNT_LAST      = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_RESUME  = 2'd3
  } state_e;

  localparam state_e     RESET_STATE = RESET_HALT ? ST_HALTED : ST_RUN;
  localparam logic [2:0] RESET_CAUSE = RESET_HALT ? CAUSE_HALTREQ : 3'd0;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       step_armed_q, step_armed_d;
  logic [2:0] cause_q, cause_d;
  logic       timeout_q, timeout_d;
  logic       running_q, halted_q, ret_q;
  logic       halt_evt;

  assign halt_evt    = ebreak_dbg | haltreq | (step_armed_q & instr_retired);
  assign dpc_capture = (state_q == ST_RUN) & halt_evt;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_armed_d = step_armed_q;
    cause_d      = cause_q;
    timeout_d    = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (halt_evt) begin
          state_d      = ST_DRAIN;
          cnt_d        = 8'd0;
          step_armed_d = 1'b0;
          if (ebreak_dbg)   cause_d = CAUSE_EBREAK;
          else if (haltreq) cause_d = CAUSE_HALTREQ;
          else              cause_d = CAUSE_STEP;
        end
      end
      ST_DRAIN: begin
        if (!bus_busy) begin
          state_d = ST_HALTED;
        end else if (cnt_q == CNT_LAST) begin
          // Bus never went idle: halt anyway and flag it for the debugger.
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HALTED: begin
        if (resumereq) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        state_d      = ST_RUN;
        step_armed_d = step;
        timeout_d    = 1'b0;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RESET_STATE;
      cnt_q        <= 8'd0;
      step_armed_q <= 1'b0;
      cause_q      <= RESET_CAUSE;
      timeout_q    <= 1'b0;
      running_q    <= !RESET_HALT;
      halted_q     <= RESET_HALT;
      ret_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_armed_q <= step_armed_d;
      cause_q      <= cause_d;
      timeout_q    <= timeout_d;
      running_q    <= (state_d == ST_RUN) || (state_d == ST_RESUME);
      halted_q     <= (state_d == ST_HALTED);
      ret_q        <= (state_d == ST_RESUME);
    end
  end

  assign core_running  = running_q;
  assign core_halted   = halted_q;
  assign halted        = halted_q;
  assign dbg_ret       = ret_q;
  assign resume_ack    = ret_q;
  assign dcsr_cause    = cause_q;
  assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a cycle-level reference model checked on every falling edge.
module tb_core_run_ctrl;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset_n, haltreq, resumereq, step, ebreak_dbg, instr_retired, bus_busy;
  logic core_running, core_halted, dbg_ret, halted, resume_ack, dpc_capture, drain_timeout;
  logic [2:0] dcsr_cause;
  logic rh_running, rh_core_halted, rh_ret, rh_halted, rh_ack, rh_dpc, rh_tmo;
  logic [2:0] rh_cause;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  core_run_ctrl #(.DRAIN_TIMEOUT(T), .RESET_HALT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .haltreq(haltreq), .resumereq(resumereq), .step(step),
    .ebreak_dbg(ebreak_dbg), .instr_retired(instr_retired), .bus_busy(bus_busy),
    .core_running(core_running), .core_halted(core_halted), .dbg_ret(dbg_ret), .halted(halted),
    .resume_ack(resume_ack), .dpc_capture(dpc_capture), .dcsr_cause(dcsr_cause),
    .drain_timeout(drain_timeout));

  core_run_ctrl #(.DRAIN_TIMEOUT(4), .RESET_HALT(1'b1)) dut_rh (
    .clk(clk), .reset_n(reset_n), .haltreq(haltreq), .resumereq(resumereq), .step(step),
    .ebreak_dbg(ebreak_dbg), .instr_retired(instr_retired), .bus_busy(bus_busy),
    .core_running(rh_running), .core_halted(rh_core_halted), .dbg_ret(rh_ret), .halted(rh_halted),
    .resume_ack(rh_ack), .dpc_capture(rh_dpc), .dcsr_cause(rh_cause),
    .drain_timeout(rh_tmo));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: debug mode flag, resume pulse flag, and number of busy cycles spent draining (-1 = not draining).
  bit       m_dbg, m_ret, m_arm, m_tmo;
  int       m_drain;
  logic [2:0] m_cause;
  logic     m_event;

  assign m_event = ebreak_dbg | haltreq | (m_arm & instr_retired);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dbg <= 1'b0; m_ret <= 1'b0; m_arm <= 1'b0; m_tmo <= 1'b0; m_drain <= -1; m_cause <= 3'd0;
    end else if (m_ret) begin
      m_ret <= 1'b0; m_arm <= step; m_tmo <= 1'b0;
    end else if (m_dbg) begin
      if (resumereq) begin m_dbg <= 1'b0; m_ret <= 1'b1; end
    end else if (m_drain >= 0) begin
      if (!bus_busy || (m_drain + 1 == T)) begin
        m_dbg <= 1'b1; m_drain <= -1;
        if (bus_busy) m_tmo <= 1'b1;
      end else begin
        m_drain <= m_drain + 1;
      end
    end else if (m_event) begin
      m_drain <= 0; m_arm <= 1'b0;
      m_cause <= ebreak_dbg ? 3'd1 : (haltreq ? 3'd3 : 3'd4);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_running", core_running, !m_dbg && (m_drain < 0));
      chk("m_core_halted", core_halted, m_dbg);
      chk("m_halted", halted, m_dbg);
      chk("m_dbg_ret", dbg_ret, m_ret);
      chk("m_resume_ack", resume_ack, m_ret);
      chk("m_dpc_capture", dpc_capture, !m_dbg && (m_drain < 0) && !m_ret && m_event);
      chk("m_cause", dcsr_cause, m_cause);
      chk("m_drain_timeout", drain_timeout, m_tmo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_halt();
    haltreq = 1'b1; tick();
    haltreq = 1'b0; tick(); tick();
  endtask

  task automatic do_resume(input logic st);
    step = st; resumereq = 1'b1; tick();
    resumereq = 1'b0; tick();
    step = 1'b0;
  endtask

  initial begin
    int n;
    bit done;
    haltreq = 0; resumereq = 0; step = 0; ebreak_dbg = 0; instr_retired = 0; bus_busy = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_running", core_running, 1); chk("rst_halted", halted, 0);
    chk("rst_core_halted", core_halted, 0); chk("rst_cause", dcsr_cause, 0);
    chk("rst_dbg_ret", dbg_ret, 0); chk("rst_tmo", drain_timeout, 0);
    chk("rh_running", rh_running, 0); chk("rh_core_halted", rh_core_halted, 1);
    chk("rh_halted", rh_halted, 1); chk("rh_cause", rh_cause, 3);
    chk("rh_ret", rh_ret | rh_ack | rh_dpc | rh_tmo, 0);
    cmp_en = 1'b1;
    tick(); tick();
    reset_n = 1'b1;

    // haltreq at cycle 5, idle bus
    repeat (5) tick();
    haltreq = 1'b1; #1 chk("halt_dpc", dpc_capture, 1);
    tick(); haltreq = 1'b0; #1 chk("halt_n1_running", core_running, 0);
    chk("halt_n1_core_halted", core_halted, 0);
    tick(); #1 chk("halt_n2_halted", halted, 1); chk("halt_n2_cause", dcsr_cause, 3);

    // resume pulse
    repeat (10) tick();
    resumereq = 1'b1; tick(); resumereq = 1'b0;
    #1 chk("res_ret", dbg_ret, 1); chk("res_ack", resume_ack, 1);
    chk("res_running", core_running, 1); chk("res_halted", halted, 0);
    tick(); #1 chk("res_ret_off", dbg_ret, 0); chk("res_run2", core_running, 1);
    chk("res_cause_kept", dcsr_cause, 3);

    // single step: retire on the 4th cycle after RUN entry
    do_halt();
    do_resume(1'b1);
    repeat (4) tick();
    instr_retired = 1'b1; #1 chk("step_dpc", dpc_capture, 1);
    tick(); instr_retired = 1'b0; #1 chk("step_drain", core_running, 0);
    tick(); #1 chk("step_halted", halted, 1); chk("step_cause", dcsr_cause, 4);

    // free run with step=0, resumereq held throughout
    resumereq = 1'b1; tick(); tick();
    instr_retired = 1'b1;
    repeat (10) tick();
    #1 chk("free_running", core_running, 1); chk("free_halted", halted, 0);
    resumereq = 1'b0; instr_retired = 1'b0;

    // 3 busy DRAIN cycles, bus idle in the 4th
    bus_busy = 1'b1; haltreq = 1'b1; tick(); haltreq = 1'b0;
    tick(); tick(); tick(); bus_busy = 1'b0;
    #1 chk("drain4_not_halted", core_halted, 0);
    tick(); #1 chk("drain4_halted", core_halted, 1); chk("drain4_tmo", drain_timeout, 0);

    // bus stuck busy: forced halt after T drain cycles
    do_resume(1'b0);
    bus_busy = 1'b1; haltreq = 1'b1; tick(); haltreq = 1'b0;
    n = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (core_halted) done = 1;
      else begin
        if (!core_running) n++;
        tick();
      end
    end
    chk("forced_reached", done, 1);
    chk("forced_cycles", n, T);
    chk("forced_tmo", drain_timeout, 1);
    bus_busy = 1'b0;
    resumereq = 1'b1; tick(); resumereq = 1'b0;
    #1 chk("tmo_in_resume", drain_timeout, 1);
    tick(); #1 chk("tmo_cleared", drain_timeout, 0);

    // ebreak and haltreq together
    ebreak_dbg = 1'b1; haltreq = 1'b1; tick();
    ebreak_dbg = 1'b0; haltreq = 1'b0; tick();
    #1 chk("ebk_halted", halted, 1); chk("ebk_cause", dcsr_cause, 1);

    // haltreq held across resume: immediate re-halt
    haltreq = 1'b1; tick();
    resumereq = 1'b1; tick(); resumereq = 1'b0;
    #1 chk("rehalt_ret", dbg_ret, 1);
    tick(); #1 chk("rehalt_run", core_running, 1); chk("rehalt_dpc", dpc_capture, 1);
    tick(); #1 chk("rehalt_drain", core_running, 0);
    haltreq = 1'b0; tick(); #1 chk("rehalt_cause", dcsr_cause, 3);

    // haltreq and step retire together
    do_resume(1'b1);
    haltreq = 1'b1; instr_retired = 1'b1; tick();
    haltreq = 1'b0; instr_retired = 1'b0; tick();
    #1 chk("hs_cause", dcsr_cause, 3);

    // reset in DRAIN
    do_resume(1'b0);
    bus_busy = 1'b1; haltreq = 1'b1; tick(); haltreq = 1'b0; tick();
    reset_n = 1'b0; #1 chk("rst_drain_run", core_running, 1); chk("rst_drain_halt", core_halted, 0);
    tick(); reset_n = 1'b1; bus_busy = 1'b0;

    // reset while step armed: no step halt afterwards
    do_halt();
    do_resume(1'b1);
    reset_n = 1'b0; #1 chk("rst_arm_run", core_running, 1);
    tick(); reset_n = 1'b1;
    instr_retired = 1'b1; repeat (3) tick();
    #1 chk("rst_arm_noh", core_running, 1); chk("rst_arm_nohalt", halted, 0);
    instr_retired = 1'b0;
    tick(); tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
